// File: rtl/substitution_layer_iter.sv
// Folded Ascon 5-bit S-box layer over a 5x64 bit-sliced state.
// Substitutes LANES columns per cycle behind valid/ready handshakes.
package ascon_pkg;
   localparam int WORD_WIDTH = 64;
   typedef logic [4:0][WORD_WIDTH-1:0] ascon_state_t;
endpackage

module substitution_layer_iter
   import ascon_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  ascon_state_t state_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output ascon_state_t state_o,
   output logic         busy_o
);

   localparam int BEATS = WORD_WIDTH / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int COL_W = $clog2(WORD_WIDTH);

   if (LANES < 1 || LANES > WORD_WIDTH ||
       (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
      $error("LANES must be a power of two in 1..WORD_WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } st_t;

   st_t               st;
   logic [CNT_W-1:0]  cnt;
   ascon_state_t      wr;
   ascon_state_t      sub;

   function automatic logic [4:0] sbox(input logic [4:0] x);
      logic [4:0] y;
      unique case (x)
         5'd0:  y = 5'h04;  5'd1:  y = 5'h0b;
         5'd2:  y = 5'h1f;  5'd3:  y = 5'h14;
         5'd4:  y = 5'h1a;  5'd5:  y = 5'h15;
         5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
         5'd8:  y = 5'h1b;  5'd9:  y = 5'h05;
         5'd10: y = 5'h08;  5'd11: y = 5'h12;
         5'd12: y = 5'h1d;  5'd13: y = 5'h03;
         5'd14: y = 5'h06;  5'd15: y = 5'h1c;
         5'd16: y = 5'h1e;  5'd17: y = 5'h13;
         5'd18: y = 5'h07;  5'd19: y = 5'h0e;
         5'd20: y = 5'h00;  5'd21: y = 5'h0d;
         5'd22: y = 5'h11;  5'd23: y = 5'h18;
         5'd24: y = 5'h10;  5'd25: y = 5'h0c;
         5'd26: y = 5'h01;  5'd27: y = 5'h19;
         5'd28: y = 5'h16;  5'd29: y = 5'h0a;
         5'd30: y = 5'h0f;  5'd31: y = 5'h17;
         default: y = 5'h00;
      endcase
      return y;
   endfunction

   // s[0] is the MSB of each column's S-box index
   always_comb begin
      logic [COL_W-1:0] col;
      logic [4:0]       idx;
      logic [4:0]       sv;
      sub = wr;
      col = '0;
      idx = '0;
      sv  = '0;
      for (int l = 0; l < LANES; l++) begin
         col = COL_W'(int'(cnt) * LANES + l);
         idx = {wr[0][col], wr[1][col], wr[2][col],
                wr[3][col], wr[4][col]};
         sv  = sbox(idx);
         sub[0][col] = sv[4];
         sub[1][col] = sv[3];
         sub[2][col] = sv[2];
         sub[3][col] = sv[1];
         sub[4][col] = sv[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= IDLE;
         cnt <= '0;
         wr  <= '0;
      end else begin
         unique case (st)
            IDLE: begin
               if (in_valid_i) begin
                  wr  <= state_i;
                  cnt <= '0;
                  st  <= RUN;
               end
            end
            RUN: begin
               wr <= sub;
               if (cnt == CNT_W'(BEATS - 1)) begin
                  cnt <= '0;
                  st  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  cnt <= '0;
                  if (in_valid_i) begin
                     wr <= state_i;
                     st <= RUN;
                  end else begin
                     st <= IDLE;
                  end
               end
            end
            default: begin
               st  <= IDLE;
               cnt <= '0;
            end
         endcase
      end
   end

   // out_ready_i -> in_ready_o is the only combinational path
   assign in_ready_o  = (st == IDLE) || ((st == DONE) && out_ready_i);
   assign out_valid_o = (st == DONE);
   assign busy_o      = (st != IDLE);
   assign state_o     = wr;

endmodule

// File: tb/tb_substitution_layer_iter.sv
// Directed bench for the folded Ascon S-box layer.
// Three instances cover LANES = 8, 1 and 64.
module tb_substitution_layer_iter;
   import ascon_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         vld [3];
   logic         ordy[3];
   logic         irdy[3];
   logic         ovld[3];
   logic         bsy [3];
   ascon_state_t sin [3];
   ascon_state_t sout[3];

   substitution_layer_iter #(.LANES(8)) u_l8 (
      .clk(clk), .rst(rst),
      .in_valid_i(vld[0]), .in_ready_o(irdy[0]),
      .state_i(sin[0]), .out_valid_o(ovld[0]),
      .out_ready_i(ordy[0]), .state_o(sout[0]),
      .busy_o(bsy[0])
   );

   substitution_layer_iter #(.LANES(1)) u_l1 (
      .clk(clk), .rst(rst),
      .in_valid_i(vld[1]), .in_ready_o(irdy[1]),
      .state_i(sin[1]), .out_valid_o(ovld[1]),
      .out_ready_i(ordy[1]), .state_o(sout[1]),
      .busy_o(bsy[1])
   );

   substitution_layer_iter #(.LANES(64)) u_l64 (
      .clk(clk), .rst(rst),
      .in_valid_i(vld[2]), .in_ready_o(irdy[2]),
      .state_i(sin[2]), .out_valid_o(ovld[2]),
      .out_ready_i(ordy[2]), .state_o(sout[2]),
      .busy_o(bsy[2])
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [4:0] sb_tab [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   task automatic chk(input string tag,
                      input logic [319:0] got,
                      input logic [319:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic ascon_state_t ref_sub(input ascon_state_t s);
      ascon_state_t r;
      logic [4:0]   x;
      logic [4:0]   y;
      r = '0;
      for (int j = 0; j < 64; j++) begin
         x = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
         y = sb_tab[x];
         {r[0][j], r[1][j], r[2][j], r[3][j], r[4][j]} = y;
      end
      return r;
   endfunction

   function automatic ascon_state_t rnd_state();
      ascon_state_t s;
      for (int i = 0; i < 5; i++)
         s[i] = {$urandom(), $urandom()};
      return s;
   endfunction

   // present st at a negedge and hold valid across the next edge
   task automatic send(input int k, input ascon_state_t st);
      @(negedge clk);
      sin[k] = st;
      vld[k] = 1'b1;
      chk("in_ready_before_accept", 320'(irdy[k]), 320'(1));
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
   endtask

   task automatic wait_out(input int k, input int lat,
                           input ascon_state_t exp,
                           input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ovld[k] && n < 300);
      chk({tag, "_latency"}, 320'(n), 320'(lat));
      chk({tag, "_data"}, sout[k], exp);
   endtask

   ascon_state_t e, x, y;
   ascon_state_t q[4];

   initial begin
      for (int i = 0; i < 3; i++) begin
         vld[i]  = 1'b0;
         ordy[i] = 1'b1;
         sin[i]  = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("reset_out_valid", 320'(ovld[0]), 320'(0));
      chk("reset_busy", 320'(bsy[0]), 320'(0));
      chk("reset_in_ready", 320'(irdy[0]), 320'(1));
      chk("reset_state", sout[0], '0);

      // all-zero: every column maps 0 -> 04
      e = '0;
      e[2] = '1;
      send(0, '0);
      wait_out(0, 8, e, "zero");

      // all-ones: 1f -> 17
      e = '1;
      e[1] = '0;
      send(0, '1);
      wait_out(0, 8, e, "ones");

      // only s[4] set: index 01 -> 0b
      x = '0;
      x[4] = '1;
      e = '0;
      e[1] = '1;
      e[3] = '1;
      e[4] = '1;
      send(0, x);
      wait_out(0, 8, e, "idx01");

      for (int r = 0; r < 2; r++) begin
         x = rnd_state();
         send(0, x);
         wait_out(0, 8, ref_sub(x), "rnd_l8");
         x = rnd_state();
         send(1, x);
         wait_out(1, 64, ref_sub(x), "rnd_l1");
         x = rnd_state();
         send(2, x);
         wait_out(2, 1, ref_sub(x), "rnd_l64");
      end

      // backpressure in DONE
      ordy[0] = 1'b0;
      x = rnd_state();
      y = rnd_state();
      send(0, x);
      wait_out(0, 8, ref_sub(x), "bp_first");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         sin[0] = y;
         vld[0] = 1'b1;
         chk("bp_in_ready", 320'(irdy[0]), 320'(0));
         @(posedge clk);
         #1;
         chk("bp_out_valid", 320'(ovld[0]), 320'(1));
         chk("bp_state_stable", sout[0], ref_sub(x));
      end
      @(negedge clk);
      ordy[0] = 1'b1;
      #1;
      chk("bp_release_ready", 320'(irdy[0]), 320'(1));
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      chk("bp_accept_busy", 320'(bsy[0]), 320'(1));
      chk("bp_accept_valid", 320'(ovld[0]), 320'(0));
      wait_out(0, 8, ref_sub(y), "bp_second");

      // back-to-back stream, accepted straight from DONE
      for (int k = 0; k < 4; k++)
         q[k] = rnd_state();
      for (int k = 0; k < 4; k++) begin
         if (k > 0)
            chk("stream_no_idle", 320'(bsy[0]), 320'(1));
         send(0, q[k]);
         wait_out(0, 8, ref_sub(q[k]), "stream");
      end

      // reset during RUN
      x = rnd_state();
      send(0, x);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrun_out_valid", 320'(ovld[0]), 320'(0));
      chk("midrun_busy", 320'(bsy[0]), 320'(0));
      chk("midrun_in_ready", 320'(irdy[0]), 320'(1));
      chk("midrun_state", sout[0], '0);
      y = rnd_state();
      send(0, y);
      wait_out(0, 8, ref_sub(y), "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
